// File: rtl/modmul_scheduler.sv
// Round-robin scheduler sharing one modular multiplier among NREQ requesters.
// Captures operands on accept, restarts the multiplier through its reset, waits
// for its completion flag (with a watchdog) and returns the result to the owner.
module modmul_scheduler #(
   parameter int unsigned n     = 256,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned SLACK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*n-1:0] req_a,
   input  logic [NREQ*n-1:0] req_b,
   input  logic [n-1:0]      p,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [n-1:0]      rsp_m,
   output logic              rsp_err,
   output logic              busy,
   output logic              mul_reset,
   output logic [n-1:0]      mul_a,
   output logic [n-1:0]      mul_b,
   output logic [n-1:0]      mul_p,
   input  logic [n-1:0]      mul_m,
   input  logic              mul_flag
);

   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CntW = $clog2(n + SLACK + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [n-1:0]      rsp_m_q, rsp_m_d;
   logic              rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;
   logic              mul_reset_q, mul_reset_d;
   logic [n-1:0]      a_q, a_d;
   logic [n-1:0]      b_q, b_d;
   logic [n-1:0]      p_q, p_d;

   logic              win_found;
   logic [IdxW-1:0]   win_idx;
   int unsigned       cand;

   // Round-robin winner: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(rr_ptr_q) + k) % NREQ;
         if (!win_found && req_valid[IdxW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IdxW'(cand);
         end
      end
   end

   // One-hot grant, only offered while idle.
   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Next-state logic for the job FSM and its registered outputs.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_m_d     = rsp_m_q;
      rsp_err_d   = rsp_err_q;
      a_d         = a_q;
      b_d         = b_q;
      p_d         = p_q;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               a_d     = req_a[int'(win_idx) * int'(n) +: n];
               b_d     = req_b[int'(win_idx) * int'(n) +: n];
               p_d     = p;
               owner_d = win_idx;
               if (p == '0) begin
                  // Zero modulus is rejected without touching the multiplier.
                  rsp_m_d              = '0;
                  rsp_err_d            = 1'b1;
                  rsp_valid_d[win_idx] = 1'b1;
                  state_d              = StDone;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            if (mul_flag) begin
               rsp_m_d              = mul_m;
               rsp_err_d            = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = StDone;
            end else if (cnt_q == CntW'(n + SLACK - 1)) begin
               // Watchdog: multiplier never completed.
               rsp_m_d              = '0;
               rsp_err_d            = 1'b1;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = StDone;
            end
         end
         StDone: begin
            rr_ptr_d = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Multiplier runs only while in RUN; held in reset otherwise.
      mul_reset_d = (state_d != StRun);
      busy_d      = (state_d != StIdle);
   end

   // State and registered-output flops, async active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_m_q     <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         mul_reset_q <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         p_q         <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_m_q     <= rsp_m_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         mul_reset_q <= mul_reset_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p_q         <= p_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_m     = rsp_m_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign mul_reset = mul_reset_q;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign mul_p     = p_q;

endmodule

// File: tb/tb_modmul_scheduler.sv
// Self-checking bench for modmul_scheduler with a behavioural multiplier stub.
module tb_modmul_scheduler;

   localparam int unsigned N     = 256;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned SLACK = 4;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [N-1:0]      p;
   logic [NREQ-1:0]   rsp_valid;
   logic [N-1:0]      rsp_m;
   logic              rsp_err;
   logic              busy;
   logic              mul_reset;
   logic [N-1:0]      mul_a;
   logic [N-1:0]      mul_b;
   logic [N-1:0]      mul_p;
   logic [N-1:0]      mul_m;
   logic              mul_flag;

   int errors = 0;
   int checks = 0;

   modmul_scheduler #(.n(N), .NREQ(NREQ), .SLACK(SLACK)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .p         (p),
      .rsp_valid (rsp_valid),
      .rsp_m     (rsp_m),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_reset (mul_reset),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .mul_m     (mul_m),
      .mul_flag  (mul_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stub: flag rises in the N-th cycle after reset drops.
   logic        stub_en;
   logic [15:0] stub_cnt;
   always_ff @(posedge clk) begin
      if (mul_reset) stub_cnt <= '0;
      else           stub_cnt <= stub_cnt + 16'd1;
   end
   assign mul_flag = stub_en && !mul_reset && (stub_cnt == 16'(N - 1));

   function automatic logic [N-1:0] modmul(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
      logic [2*N-1:0] prod;
      if (m == '0) return '0;
      prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      return N'(prod % {{N{1'b0}}, m});
   endfunction

   assign mul_m = stub_en ? modmul(mul_a, mul_b, mul_p) : '0;

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[0] = 1'b1;
      return v << i;
   endfunction

   function automatic logic [N-1:0] rand_n();
      logic [N-1:0] r;
      for (int w = 0; w < N / 32; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Issue one request from idx, wait for its response and check it.
   task automatic do_job(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] pm, input logic [N-1:0] exp_m,
                         input logic exp_err, input int exp_lat);
      int   lat;
      logic seen;
      logic mr_all;
      @(negedge clk);
      req_valid              = oh(idx);
      req_a[idx*N +: N]      = a;
      req_b[idx*N +: N]      = b;
      p                      = pm;
      #1;
      chk("req_ready", N'(req_ready), N'(oh(idx)));
      @(negedge clk);
      req_valid = '0;
      lat    = 1;
      seen   = 1'b0;
      mr_all = 1'b1;
      while (!seen && lat <= int'(N + SLACK + 8)) begin
         mr_all &= mul_reset;
         if (rsp_valid != '0) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk("rsp_seen", N'(seen), N'(1));
      if (seen) begin
         chk("latency",   N'(lat),       N'(exp_lat));
         chk("rsp_owner", N'(rsp_valid), N'(oh(idx)));
         chk("rsp_m",     rsp_m,         exp_m);
         chk("rsp_err",   N'(rsp_err),   N'(exp_err));
         if (exp_err && exp_lat == 1) chk("mul_reset_held", N'(mr_all), N'(1));
         @(negedge clk);
         chk("rsp_pulse", N'(rsp_valid), '0);
      end
   endtask

   typedef struct {
      int           idx;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] pm;
      logic [N-1:0] m;
      logic         err;
      int           lat;
   } vec_t;

   vec_t         vecs[8];
   logic [N-1:0] p25519;
   logic [N-1:0] ra, rb;
   int           ri;
   int           guard;
   logic         stray;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Directed table; last entry uses requester 3 so rr_ptr returns to 0.
      vecs[0] = '{0, N'(3),   N'(5),   N'(7),   N'(1), 1'b0, N + 2};
      vecs[1] = '{1, N'(10),  N'(10),  N'(13),  N'(9), 1'b0, N + 2};
      vecs[2] = '{2, N'(6),   N'(7),   N'(0),   N'(0), 1'b1, 1};
      vecs[3] = '{3, N'(255), N'(2),   N'(11),  N'(4), 1'b0, N + 2};
      vecs[4] = '{2, N'(12),  N'(12),  N'(5),   N'(4), 1'b0, N + 2};
      vecs[5] = '{1, N'(16),  N'(16),  N'(255), N'(1), 1'b0, N + 2};
      vecs[6] = '{0, N'(0),   N'(9),   N'(17),  N'(0), 1'b0, N + 2};
      vecs[7] = '{3, N'(1),   N'(1),   N'(2),   N'(1), 1'b0, N + 2};

      p25519    = {1'b0, {(N-1){1'b1}}} - N'(18);
      stub_en   = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      p         = '0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",      N'(busy),      '0);
      chk("rst_rsp_valid", N'(rsp_valid), '0);
      chk("rst_mul_reset", N'(mul_reset), N'(1));
      chk("rst_rsp_m",     rsp_m,         '0);
      chk("rst_mul_p",     mul_p,         '0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_job(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].pm, vecs[i].m, vecs[i].err,
                vecs[i].lat);
      end

      // All four requesters held valid: grants 0,1,2,3,0.
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = N'(i + 2);
         req_b[i*N +: N] = N'(3);
      end
      p         = N'(101);
      req_valid = '1;
      for (int g = 0; g < 5; g++) begin
         guard = 0;
         while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         #1;
         chk("rr_grant", N'(req_ready), N'(oh(g % 4)));
         @(negedge clk);
         chk("rr_busy", N'(busy), N'(1));
         guard = 0;
         while (rsp_valid == '0 && guard < int'(N + SLACK + 8)) begin
            @(negedge clk);
            guard++;
         end
         chk("rr_owner", N'(rsp_valid), N'(oh(g % 4)));
         chk("rr_m",     rsp_m,         N'(((g % 4) + 2) * 3 % 101));
         if (g == 4) req_valid = '0;
         @(negedge clk);
         chk("rr_pulse", N'(rsp_valid), '0);
      end

      // Watchdog: stub never raises flag, then a normal job.
      stub_en = 1'b0;
      do_job(1, N'(5), N'(6), N'(7), N'(0), 1'b1, N + SLACK + 2);
      stub_en = 1'b1;
      do_job(1, N'(5), N'(6), N'(7), N'(2), 1'b0, N + 2);

      // Reset in RUN at cnt=100: job dropped, outputs back to reset values.
      @(negedge clk);
      req_valid       = oh(2);
      req_a[2*N +: N] = N'(9);
      req_b[2*N +: N] = N'(9);
      p               = N'(10);
      @(negedge clk);
      req_valid = '0;
      repeat (101) @(negedge clk);
      chk("pre_rst_busy", N'(mul_reset), '0);
      reset = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", N'(rsp_valid), '0);
      chk("mid_rst_busy",      N'(busy),      '0);
      chk("mid_rst_mul_reset", N'(mul_reset), N'(1));
      chk("mid_rst_mul_a",     mul_a,         '0);
      chk("mid_rst_rsp_m",     rsp_m,         '0);
      chk("mid_rst_rsp_err",   N'(rsp_err),   '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stray = 1'b0;
      repeat (N + 8) begin
         @(negedge clk);
         if (rsp_valid != '0) stray = 1'b1;
      end
      chk("no_rsp_after_rst", N'(stray), '0);
      do_job(2, N'(9), N'(9), N'(10), N'(1), 1'b0, N + 2);

      // Random jobs modulo 2^255-19 from mixed requesters.
      for (int j = 0; j < 200; j++) begin
         ri = int'($urandom_range(NREQ - 1, 0));
         ra = rand_n() % p25519;
         rb = rand_n() % p25519;
         do_job(ri, ra, rb, p25519, modmul(ra, rb, p25519), 1'b0, N + 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
